fifo_rd_drain: RTL and testbench

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/fifo_drain_pkg.sv | 14 +
 rtl/fifo_lane_sel.sv | 24 ++
 rtl/fifo_rd_drain.sv | 124 ++++++++++++
 tb/tb_fifo_rd_drain.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg -- shared types and defaults for the FIFO read-side drain.
//   DEF_IN_W / DEF_OUT_W : default FIFO word width and output beat width
//   slot_state_e         : occupancy of the SHIFT/PEND slot pair
package fifo_drain_pkg;
  localparam int DEF_IN_W  = 256;
  localparam int DEF_OUT_W = 32;

  // EMPTY: no word buffered; ONE: SHIFT holds a word; FULL: SHIFT and PEND hold words
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slot_state_e;
endpackage

// File: rtl/fifo_lane_sel.sv
// fifo_lane_sel -- selects one OUT_W beat from an IN_W word, MSB lane first.
//   i_word : IN_W word being serialized
//   i_lane : beat index (0 = most significant lane)
//   o_beat : selected OUT_W beat
module fifo_lane_sel
  import fifo_drain_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int RATIO = IN_W / OUT_W,
  parameter int LW    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic [IN_W-1:0]  i_word,
  input  logic [LW-1:0]    i_lane,
  output logic [OUT_W-1:0] o_beat
);
  logic [RATIO-1:0][OUT_W-1:0] w_lanes;
  logic [LW-1:0]               w_idx;

  assign w_lanes = i_word;
  // beat 0 is the top lane, so the packed index runs backwards
  assign w_idx   = LW'(RATIO - 1) - i_lane;
  assign o_beat  = w_lanes[w_idx];
endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain -- reads IN_W words from a FIFO and serializes them into
// OUT_W beats with valid/ready handshake. One word is shifted out while a
// second can be prefetched, so back-to-back words stream without a bubble.
//   rd_clk, rst_n            : clock, synchronous active-low reset
//   fifo_dout/empty/valid    : FIFO read side (valid one cycle after rd_en)
//   fifo_rd_rst_busy         : FIFO read-side reset in progress, blocks reads
//   fifo_rd_en               : FIFO read strobe
//   m_data/m_valid/m_ready   : beat stream, m_last on the final beat of a word
//   err_unexp                : sticky, fifo_valid seen with no read outstanding
// Optional: define FIFO_DRAIN_STATS_EN to add beat_cnt and stall_cnt outputs.
module fifo_rd_drain
  import fifo_drain_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic             fifo_rd_rst_busy,
  output logic             fifo_rd_en,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             err_unexp
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0]      beat_cnt,
  output logic [31:0]      stall_cnt
`endif
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  slot_state_e      r_state;
  logic [IN_W-1:0]  r_shift;
  logic [IN_W-1:0]  r_pend;
  logic [LW-1:0]    r_lane;
  logic             r_out;   // read issued last cycle, data due this cycle
  logic             r_skip;  // first cycle after reset: drop a stray fifo_valid
  logic             r_err;

  logic             w_xfer;
  logic             w_drain;
  logic             w_load;
  logic             w_unexp;
  logic [OUT_W-1:0] w_beat;

  assign m_valid   = (r_state != EMPTY);
  assign m_last    = m_valid && (r_lane == LAST_LANE);
  assign m_data    = m_valid ? w_beat : '0;
  assign err_unexp = r_err;

  assign w_xfer  = m_valid && m_ready;
  assign w_drain = w_xfer && (r_lane == LAST_LANE);
  assign w_load  = fifo_valid && r_out;
  assign w_unexp = fifo_valid && !r_out && !r_skip;

  // With no read outstanding, occupancy + outstanding < 2 reduces to "not FULL".
  assign fifo_rd_en = rst_n && !fifo_rd_rst_busy && !fifo_empty && !r_out &&
                      (r_state != FULL);

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_lane  <= '0;
      r_out   <= 1'b0;
      r_skip  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_out  <= fifo_rd_en;
      r_skip <= 1'b0;
      if (w_unexp) r_err <= 1'b1;
      if (w_xfer)  r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
      case (r_state)
        EMPTY: if (w_load) begin
          r_shift <= fifo_dout;
          r_state <= ONE;
        end
        ONE: begin
          // a word arriving on the last beat goes straight into SHIFT
          if (w_load && w_drain) r_shift <= fifo_dout;
          else if (w_load) begin
            r_pend  <= fifo_dout;
            r_state <= FULL;
          end else if (w_drain) r_state <= EMPTY;
        end
        FULL: if (w_drain) begin
          r_shift <= r_pend;
          r_state <= ONE;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  fifo_lane_sel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane_sel (
    .i_word (r_shift),
    .i_lane (r_lane),
    .o_beat (w_beat)
  );

`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_xfer)              r_beat_cnt  <= r_beat_cnt + 32'd1;
      if (m_valid && !m_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign beat_cnt  = r_beat_cnt;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain -- self-checking bench for fifo_rd_drain: FIFO model,
// beat scoreboard, table of words/ready patterns, and directed corner cases.
// Define FIFO_DRAIN_STATS_EN to also check beat_cnt/stall_cnt.
module tb_fifo_rd_drain;
  localparam int IN_W  = 256;
  localparam int OUT_W = 32;
  localparam int RATIO = IN_W / OUT_W;

  logic             rd_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IN_W-1:0]  fifo_dout = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_valid = 1'b0;
  logic             fifo_rd_rst_busy = 1'b0;
  logic             fifo_rd_en;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic             err_unexp;
`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0]      beat_cnt;
  logic [31:0]      stall_cnt;
`endif

  always #5 rd_clk = ~rd_clk;

  fifo_rd_drain #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .rd_clk           (rd_clk),
    .rst_n            (rst_n),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_valid       (fifo_valid),
    .fifo_rd_rst_busy (fifo_rd_rst_busy),
    .fifo_rd_en       (fifo_rd_en),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last),
    .err_unexp        (err_unexp)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .beat_cnt         (beat_cnt),
    .stall_cnt        (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    logic [IN_W-1:0]  word;
    logic [15:0]      rmask;
    logic [OUT_W-1:0] b0;
    logic [OUT_W-1:0] b7;
  } vec_t;

  beat_t            exp_q[$];
  logic [IN_W-1:0]  fq[$];
  vec_t             tbl[4];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_xfer = 0, n_rd = 0, n_lastx = 0, xfer_rst = 0;
  int first_cyc = -1, last_cyc = -1, beat_idx = 0;
  logic             rd_pend = 1'b0;
  logic [IN_W-1:0]  rd_data = '0;
  logic             prev_rd = 1'b0;
  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  logic             prev_last = 1'b0;
  logic [OUT_W-1:0] obs_b0 = '0, obs_b7 = '0;
  // staged inputs, applied at the next falling edge
  logic nx_rst_n = 1'b0, nx_ready = 1'b0, nx_busy = 1'b0, nx_force = 1'b0;

  task automatic chk(input string nm, input logic [IN_W-1:0] act,
                     input logic [IN_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [IN_W-1:0] w);
    beat_t b;
    fq.push_back(w);
    for (int k = 0; k < RATIO; k++) begin
      b.data = w[IN_W-1-k*OUT_W -: OUT_W];
      b.last = (k == RATIO - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later.
  task automatic tick();
    beat_t e;
    @(negedge rd_clk);
    rst_n            = nx_rst_n;
    m_ready          = nx_ready;
    fifo_rd_rst_busy = nx_busy;
    fifo_valid       = rd_pend || nx_force;
    fifo_dout        = rd_pend ? rd_data : '0;
    rd_pend          = 1'b0;
    fifo_empty       = (fq.size() == 0);
    #1;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      fq.delete();
      beat_idx = 0;
      xfer_rst = 0;
    end
    if (stall_prev) begin
      chk("stable_data", m_data, prev_data);
      chk("stable_last", m_last, prev_last);
    end
    if (fifo_rd_en) begin
      n_rd++;
      chk("rd_en_legal", {fifo_empty, fifo_rd_rst_busy, !rst_n, prev_rd}, '0);
      if (fq.size() > 0) begin
        rd_pend = 1'b1;
        rd_data = fq.pop_front();
      end
    end
    prev_rd = fifo_rd_en;
    if (m_valid && m_ready && rst_n) begin
      n_xfer++;
      xfer_rst++;
      if (m_last) n_lastx++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (beat_idx == 0) obs_b0 = m_data;
      if (beat_idx == RATIO - 1) obs_b7 = m_data;
      beat_idx = (beat_idx + 1) % RATIO;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_extra: got beat %0h expected none", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_data, e.data);
        chk("beat_last", m_last, e.last);
      end
    end
    stall_prev = m_valid && !m_ready && rst_n;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic run_drain(input string nm, input int max);
    for (int i = 0; i < max && (exp_q.size() != 0 || fq.size() != 0 || rd_pend); i++)
      tick();
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, m_valid, 0);
    chk({nm, "_last"}, m_last, 0);
    chk({nm, "_data"}, m_data, 0);
    chk({nm, "_rd_en"}, fifo_rd_en, 0);
  endtask

  initial begin
    logic [IN_W-1:0] w;
    int x0, r0, l0;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] s0;
`endif
    // table: word, ready pattern, expected first and last beat
    w = '0;
    for (int k = 0; k < RATIO; k++) w[IN_W-1-k*OUT_W -: OUT_W] = 32'(32'h1111_1111 * (k + 1));
    tbl[0] = '{word: {8{32'hDEAD_BEEF}}, rmask: 16'hFFFF, b0: 32'hDEAD_BEEF, b7: 32'hDEAD_BEEF};
    tbl[1] = '{word: 256'h1,              rmask: 16'hAAAA, b0: 32'h0,         b7: 32'h1};
    tbl[2] = '{word: {32'h8000_0000, 224'h0}, rmask: 16'h3333, b0: 32'h8000_0000, b7: 32'h0};
    tbl[3] = '{word: w,                   rmask: 16'h0F0F, b0: 32'h1111_1111, b7: 32'h8888_8888};

    // reset state
    nx_rst_n = 1'b0;
    tick(); tick();
    chk_idle("rst");
    chk("rst_err", err_unexp, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    nx_rst_n = 1'b1;
    tick();

    // single word, 8 consecutive beats 7..0, one m_last
    w = '0;
    for (int k = 0; k < RATIO; k++) w[IN_W-1-k*OUT_W -: OUT_W] = 32'(RATIO - 1 - k);
    nx_ready = 1'b1;
    first_cyc = -1;
    l0 = n_lastx;
    push_word(w);
    run_drain("t1_drain", 40);
    chk("t1_span", last_cyc - first_cyc + 1, RATIO);
    chk("t1_lasts", n_lastx - l0, 1);
    chk("t1_first", obs_b0, 32'd7);
    tick();
    chk("t1_idle", m_valid, 0);

    // table-driven words under varied ready patterns
    for (int t = 0; t < 4; t++) begin
      push_word(tbl[t].word);
      for (int i = 0; i < 200 && (exp_q.size() != 0 || fq.size() != 0 || rd_pend); i++) begin
        nx_ready = tbl[t].rmask[i % 16];
        tick();
      end
      chk($sformatf("tbl%0d_drain", t), exp_q.size(), 0);
      chk($sformatf("tbl%0d_b0", t), obs_b0, tbl[t].b0);
      chk($sformatf("tbl%0d_b7", t), obs_b7, tbl[t].b7);
    end
    nx_ready = 1'b1;
    tick(); tick();

    // three words stream with no gap
    first_cyc = -1;
    r0 = n_rd;
    for (int i = 0; i < 3; i++) push_word({8{$urandom()}} ^ IN_W'(i));
    run_drain("t3_drain", 80);
    chk("t3_span", last_cyc - first_cyc + 1, 3 * RATIO);
    chk("t3_reads", n_rd - r0, 3);
    tick();

    // 20-cycle stall after the first beat
    x0 = n_xfer;
    for (int i = 0; i < 3; i++) push_word({8{$urandom()}});
    for (int i = 0; i < 20 && n_xfer == x0; i++) tick();
    chk("st_first", n_xfer - x0, 1);
`ifdef FIFO_DRAIN_STATS_EN
    s0 = stall_cnt;
`endif
    r0 = n_rd;
    nx_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("st_no_rd", n_rd - r0, 0);
    chk("st_pend_full", fq.size(), 1);
    chk("st_no_xfer", n_xfer - x0, 1);
    nx_ready = 1'b1;
    tick();
`ifdef FIFO_DRAIN_STATS_EN
    chk("st_stall_cnt", stall_cnt - s0, 20);
`endif
    run_drain("st_drain", 80);
    tick();

    // rd_rst_busy blocks reads but the buffered word drains
    nx_ready = 1'b0;
    push_word({8{32'hCAFE_0001}});
    for (int i = 0; i < 10 && !m_valid; i++) tick();
    chk("bz_loaded", m_valid, 1);
    nx_busy  = 1'b1;
    nx_ready = 1'b1;
    push_word({8{32'h5A5A_0002}});
    r0 = n_rd;
    x0 = n_xfer;
    for (int i = 0; i < 12; i++) tick();
    chk("bz_no_rd", n_rd - r0, 0);
    chk("bz_drained", n_xfer - x0, RATIO);
    chk("bz_empty", m_valid, 0);
    nx_busy = 1'b0;
    run_drain("bz_drain", 40);
    tick();

    // unexpected fifo_valid while idle
    chk("ue_pre", err_unexp, 0);
    nx_force = 1'b1;
    tick();
    nx_force = 1'b0;
    tick();
    chk("ue_err", err_unexp, 1);
    chk("ue_valid", m_valid, 0);
    tick(); tick();
    chk("ue_sticky", err_unexp, 1);

    // reset on beat 3 aborts the word; next word restarts at beat 0
    push_word({8{32'h0BAD_0BAD}});
    for (int i = 0; i < 20 && beat_idx != 3; i++) tick();
    chk("rs_at3", beat_idx, 3);
    nx_rst_n = 1'b0;
    tick();
    tick();
    chk_idle("rs");
    chk("rs_err", err_unexp, 0);
    nx_rst_n = 1'b1;
    tick();
    chk("rs_err_post", err_unexp, 0);
    w = '0;
    for (int k = 0; k < RATIO; k++) w[IN_W-1-k*OUT_W -: OUT_W] = 32'h100 + 32'(k);
    push_word(w);
    run_drain("rs_drain", 40);
    chk("rs_b0", obs_b0, 32'h100);
`ifdef FIFO_DRAIN_STATS_EN
    chk("beat_cnt", beat_cnt, xfer_rst);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
